id_ex_pipe: RTL and testbench
=============================

ID_EX_PIPE -- requirements
Module: id_ex_pipe

Interface
REQ-001 SHALL have parameter DATA_W, default 32, operand width.
REQ-002 SHALL have parameter ALUOP_W, default 7, aluop width.
REQ-003 SHALL have parameter ALUSEL_W, default 3, primary alusel width.
REQ-004 SHALL have parameter ALUSEL2_W, default 7, secondary alusel width.
REQ-005 SHALL have parameter WD_W, default 5, destination register index width.
REQ-006 SHALL have port clk  in  1  clock; all state on rising edge.
REQ-007 SHALL have port rst_n  in  1  asynchronous active-low reset.
REQ-008 SHALL have port flush  in  1  discard all held entries.
REQ-009 SHALL have port id_valid  in  1  ID payload valid.
REQ-010 SHALL have port id_ready  out  1  stage accepts ID payload.
REQ-011 SHALL have ports id_aluop/id_alusel/id_alusel2  in  ALUOP_W/ALUSEL_W/ALUSEL2_W  ALU control.
REQ-012 SHALL have ports id_reg1, id_reg2  in  DATA_W each  operands.
REQ-013 SHALL have ports id_wd  in  WD_W, id_wreg  in  1  destination index, write enable.
REQ-014 SHALL have port ex_valid  out  1  EX payload valid.
REQ-015 SHALL have port ex_ready  in  1  EX consumes payload.
REQ-016 SHALL have ports ex_aluop/ex_alusel/ex_alusel2/ex_reg1/ex_reg2/ex_wd/ex_wreg  out  widths as ID side  registered payload.

Function
REQ-017 Transfer SHALL occur on ID side when id_valid & id_ready, on EX side when ex_valid & ex_ready.
REQ-018 Storage SHALL be main register (drives ex_*) plus one skid register; states EMPTY, FULL (main only), SKID (both).
REQ-019 EMPTY: ID transfer -> FULL; else stay.
REQ-020 FULL: ID+EX transfer -> FULL with new data; EX only -> EMPTY; ID only -> SKID (new data into skid); neither -> stay.
REQ-021 SKID: EX transfer -> FULL with skid moved to main; else stay; id_ready SHALL be 0.
REQ-022 id_ready SHALL be a register output equal to (state != SKID); no combinational path ex_ready -> id_ready.
REQ-023 Latency SHALL be 1 cycle from ID transfer to ex_valid when empty; order strictly FIFO, no loss, no duplication.
REQ-024 ex_valid SHALL be 1 exactly in FULL and SKID.
REQ-025 ex_wreg SHALL be 0 whenever ex_valid is 0, regardless of stored payload.
REQ-026 flush SHALL force EMPTY next cycle and take priority over any simultaneous ID transfer (flushed input dropped).
REQ-027 ex_* payload other than ex_wreg SHALL hold last value while stalled or empty.

Reset
REQ-028 rst_n low SHALL immediately set state EMPTY, ex_valid 0, id_ready 0, all ex_* payload 0.
REQ-029 id_ready SHALL become 1 on first clk edge after rst_n deasserts; reset mid-transfer SHALL drop all entries.

Configuration
REQ-030 Macro ID_EX_SKID_EN defined: behaviour as REQ-018..022.
REQ-031 Macro undefined: no skid register, no SKID state; id_ready = ~ex_valid | ex_ready (combinational, not 0 in reset beyond ex_valid=0 rule: id_ready 1 during reset); all other requirements unchanged.

Structure
REQ-032 Shared package SHALL hold default widths and the state encoding (EMPTY=2'd0, FULL=2'd1, SKID=2'd2).
REQ-033 Payload SHALL be packed into one vector; a sub-module id_ex_slot (enable-loaded payload register, async reset to 0) SHALL be instantiated for main and skid.

Verification
REQ-034 Reset then id_valid=1, id_reg1=0x12345678, ex_ready=1 -> next cycle ex_valid=1, ex_reg1=0x12345678.
REQ-035 Stream A,B,C with ex_ready=0 from cycle of B -> id_ready=0 after B accepted; ex_reg1 holds A; release ex_ready -> A,B,C in order, C accepted only after release.
REQ-036 FULL, flush=1 with id_valid=1 (id_wd=5'd7) -> next cycle ex_valid=0, ex_wreg=0, dropped entry never appears.
REQ-037 Continuous id_valid=1, ex_ready=1 for 8 cycles -> 8 transfers, throughput 1/cycle, no bubbles.
REQ-038 rst_n low mid-SKID -> ex_valid=0, ex_reg2=0 immediately, before next clk edge.
REQ-039 Build without ID_EX_SKID_EN, ex_valid=1, ex_ready=0 -> id_ready=0 same cycle; ex_ready=1 -> id_ready=1 same cycle.

Source files
------------

// File: rtl/id_ex_pipe_pkg.sv
// Shared definitions for the ID/EX pipeline register: default payload widths
// and the occupancy state encoding.
package id_ex_pipe_pkg;

  localparam int DATA_W_DEF    = 32;
  localparam int ALUOP_W_DEF   = 7;
  localparam int ALUSEL_W_DEF  = 3;
  localparam int ALUSEL2_W_DEF = 7;
  localparam int WD_W_DEF      = 5;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } state_t;

  // Width of the packed payload vector {aluop, alusel, alusel2, reg1, reg2, wd, wreg}.
  function automatic int payload_width(input int data_w, input int aluop_w,
                                       input int alusel_w, input int alusel2_w,
                                       input int wd_w);
    return aluop_w + alusel_w + alusel2_w + 2 * data_w + wd_w + 1;
  endfunction

endpackage

// File: rtl/id_ex_slot.sv
// Enable-loaded payload register with asynchronous clear; used for both the
// main (EX-facing) entry and the skid entry of id_ex_pipe.
module id_ex_slot #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // NOTE: the payload is cleared on reset because ex_* outputs must read as 0
  // while rst_n is low; a wide datapath register would normally skip this.
  // NOTE: sequential state uses non-blocking (<=) so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/id_ex_pipe.sv
// ID/EX pipeline register with valid/ready handshakes. Define ID_EX_SKID_EN for
// a registered id_ready with a one-entry skid buffer; otherwise id_ready is
// combinational (~ex_valid | ex_ready) and only the main entry exists.
module id_ex_pipe
  import id_ex_pipe_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int ALUOP_W   = ALUOP_W_DEF,
  parameter int ALUSEL_W  = ALUSEL_W_DEF,
  parameter int ALUSEL2_W = ALUSEL2_W_DEF,
  parameter int WD_W      = WD_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 id_valid,
  output logic                 id_ready,
  input  logic [ALUOP_W-1:0]   id_aluop,
  input  logic [ALUSEL_W-1:0]  id_alusel,
  input  logic [ALUSEL2_W-1:0] id_alusel2,
  input  logic [DATA_W-1:0]    id_reg1,
  input  logic [DATA_W-1:0]    id_reg2,
  input  logic [WD_W-1:0]      id_wd,
  input  logic                 id_wreg,
  output logic                 ex_valid,
  input  logic                 ex_ready,
  output logic [ALUOP_W-1:0]   ex_aluop,
  output logic [ALUSEL_W-1:0]  ex_alusel,
  output logic [ALUSEL2_W-1:0] ex_alusel2,
  output logic [DATA_W-1:0]    ex_reg1,
  output logic [DATA_W-1:0]    ex_reg2,
  output logic [WD_W-1:0]      ex_wd,
  output logic                 ex_wreg
);

  localparam int PAY_W = payload_width(DATA_W, ALUOP_W, ALUSEL_W, ALUSEL2_W, WD_W);

  state_t           state, state_nx;
  logic [PAY_W-1:0] id_pay, main_d, main_q;
  logic             main_en;
  logic             main_wreg;
  logic             id_xfer, ex_xfer;

  assign id_pay   = {id_aluop, id_alusel, id_alusel2, id_reg1, id_reg2, id_wd, id_wreg};
  assign ex_valid = (state == ST_FULL) || (state == ST_SKID);
  assign id_xfer  = id_valid & id_ready;
  assign ex_xfer  = ex_valid & ex_ready;

`ifdef ID_EX_SKID_EN
  logic [PAY_W-1:0] skid_q;
  logic             skid_en;
  logic             id_ready_q;

  // id_ready is looked up from next state so it is a pure flop output,
  // breaking any combinational ex_ready -> id_ready path.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_ready_q <= 1'b0;
    end else begin
      id_ready_q <= (state_nx != ST_SKID);
    end
  end

  assign id_ready = id_ready_q;
  assign main_d   = (state == ST_SKID) ? skid_q : id_pay;

  id_ex_slot #(.W(PAY_W)) u_skid (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (skid_en),
    .d     (id_pay),
    .q     (skid_q)
  );
`else
  assign id_ready = ~ex_valid | ex_ready;
  assign main_d   = id_pay;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_EMPTY;
    end else begin
      state <= state_nx;
    end
  end

  // NOTE: every output of this block gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_nx = state;
    main_en  = 1'b0;
`ifdef ID_EX_SKID_EN
    skid_en  = 1'b0;
`endif
    if (flush) begin
      // Flush wins over a simultaneous ID transfer: nothing is loaded.
      state_nx = ST_EMPTY;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (id_xfer) begin
            state_nx = ST_FULL;
            main_en  = 1'b1;
          end
        end
        ST_FULL: begin
          if (id_xfer && ex_xfer) begin
            main_en = 1'b1;
          end else if (ex_xfer) begin
            state_nx = ST_EMPTY;
          end else if (id_xfer) begin
`ifdef ID_EX_SKID_EN
            state_nx = ST_SKID;
            skid_en  = 1'b1;
`else
            // Unreachable: id_ready is low while full and not draining.
            state_nx = ST_FULL;
`endif
          end
        end
        ST_SKID: begin
`ifdef ID_EX_SKID_EN
          if (ex_xfer) begin
            state_nx = ST_FULL;
            main_en  = 1'b1;
          end
`else
          state_nx = ST_EMPTY;
`endif
        end
        default: state_nx = ST_EMPTY;
      endcase
    end
  end

  id_ex_slot #(.W(PAY_W)) u_main (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (main_en),
    .d     (main_d),
    .q     (main_q)
  );

  assign {ex_aluop, ex_alusel, ex_alusel2, ex_reg1, ex_reg2, ex_wd, main_wreg} = main_q;

  // A stale register write must never reach EX when the slot is empty.
  assign ex_wreg = main_wreg & ex_valid;

endmodule

// File: tb/tb_id_ex_pipe.sv
// Self-checking bench for id_ex_pipe: scoreboard queue of accepted payloads,
// a vector table for basic traffic, and directed stall/flush/reset sequences.
module tb_id_ex_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        id_valid = 1'b0;
  logic        id_ready;
  logic [6:0]  id_aluop = '0;
  logic [2:0]  id_alusel = '0;
  logic [6:0]  id_alusel2 = '0;
  logic [31:0] id_reg1 = '0;
  logic [31:0] id_reg2 = '0;
  logic [4:0]  id_wd = '0;
  logic        id_wreg = 1'b0;
  logic        ex_valid;
  logic        ex_ready = 1'b0;
  logic [6:0]  ex_aluop;
  logic [2:0]  ex_alusel;
  logic [6:0]  ex_alusel2;
  logic [31:0] ex_reg1;
  logic [31:0] ex_reg2;
  logic [4:0]  ex_wd;
  logic        ex_wreg;

  id_ex_pipe dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .id_valid   (id_valid),
    .id_ready   (id_ready),
    .id_aluop   (id_aluop),
    .id_alusel  (id_alusel),
    .id_alusel2 (id_alusel2),
    .id_reg1    (id_reg1),
    .id_reg2    (id_reg2),
    .id_wd      (id_wd),
    .id_wreg    (id_wreg),
    .ex_valid   (ex_valid),
    .ex_ready   (ex_ready),
    .ex_aluop   (ex_aluop),
    .ex_alusel  (ex_alusel),
    .ex_alusel2 (ex_alusel2),
    .ex_reg1    (ex_reg1),
    .ex_reg2    (ex_reg2),
    .ex_wd      (ex_wd),
    .ex_wreg    (ex_wreg)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [6:0]  aluop;
    logic [2:0]  alusel;
    logic [6:0]  alusel2;
    logic [31:0] reg1;
    logic [31:0] reg2;
    logic [4:0]  wd;
    logic        wreg;
  } pay_t;

  typedef struct {
    logic        iv;
    logic        er;
    logic [31:0] r1;
    logic        exp_v;
    logic [31:0] exp_r1;
  } vec_t;

  pay_t q[$];
  pay_t pend[$];
  int   total = 0;
  int   bad = 0;
  int   pops = 0;
  bit   armed = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic pay_t mk(input logic [31:0] k);
    pay_t p;
    p.aluop   = k[6:0] ^ 7'h2a;
    p.alusel  = k[10:8];
    p.alusel2 = k[22:16] ^ 7'h11;
    p.reg1    = k;
    p.reg2    = ~k ^ 32'h0f0f_0000;
    p.wd      = k[4:0] ^ 5'h3;
    p.wreg    = k[0] | k[5];
    return p;
  endfunction

  function automatic logic exp_ready(input logic er);
`ifdef ID_EX_SKID_EN
    return armed && (q.size() < 2);
`else
    return (q.size() == 0) || er;
`endif
  endfunction

  // One clock: drive at posedge+1, check at posedge+4, update the model, advance.
  task automatic step(input logic iv, input logic er, input logic fl, input pay_t p,
                      output logic acc);
    pay_t h;
    logic exp_rdy, ex_x;
    id_valid = iv; ex_ready = er; flush = fl;
    {id_aluop, id_alusel, id_alusel2, id_reg1, id_reg2, id_wd, id_wreg} = p;
    #3;
    exp_rdy = exp_ready(er);
    check("id_ready", id_ready, exp_rdy);
    check("ex_valid", ex_valid, q.size() > 0);
    if (q.size() > 0) begin
      h = q[0];
      check("ex_reg1", ex_reg1, h.reg1);
      check("ex_reg2", ex_reg2, h.reg2);
      check("ex_ctl", {ex_aluop, ex_alusel, ex_alusel2, ex_wd},
            {h.aluop, h.alusel, h.alusel2, h.wd});
      check("ex_wreg", ex_wreg, h.wreg);
    end else begin
      check("ex_wreg_idle", ex_wreg, 1'b0);
    end
    acc  = iv && exp_rdy && !fl;
    ex_x = (q.size() > 0) && er;
    if (fl) begin
      q.delete();
    end else begin
      if (ex_x) begin
        void'(q.pop_front());
        pops++;
      end
      if (acc) q.push_back(p);
    end
    @(posedge clk);
    #1;
    armed = 1'b1;
  endtask

  // Present pending items (valid held until accepted) for n cycles.
  task automatic run(input int n, input logic er);
    logic a;
    for (int i = 0; i < n; i++) begin
      if (pend.size() > 0) begin
        step(1'b1, er, 1'b0, pend[0], a);
        if (a) void'(pend.pop_front());
      end else begin
        step(1'b0, er, 1'b0, mk(32'h0), a);
      end
    end
  endtask

  vec_t vt[8];

  initial begin
    logic a;
    int   p0;
    pay_t pa;

    vt[0] = '{1'b1, 1'b1, 32'h1234_5678, 1'b1, 32'h1234_5678};
    vt[1] = '{1'b1, 1'b1, 32'h0000_00a1, 1'b1, 32'h0000_00a1};
    vt[2] = '{1'b0, 1'b1, 32'h0,         1'b0, 32'h0000_00a1};
    vt[3] = '{1'b0, 1'b0, 32'h0,         1'b0, 32'h0000_00a1};
    vt[4] = '{1'b1, 1'b0, 32'h0000_b2b2, 1'b1, 32'h0000_b2b2};
    vt[5] = '{1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_b2b2};
    vt[6] = '{1'b1, 1'b1, 32'h00c3_0c3c, 1'b1, 32'h00c3_0c3c};
    vt[7] = '{1'b0, 1'b1, 32'h0,         1'b0, 32'h00c3_0c3c};

    // Reset state.
    #2;
    check("rst_ex_valid", ex_valid, 1'b0);
    check("rst_ex_wreg", ex_wreg, 1'b0);
    check("rst_ex_reg1", ex_reg1, 32'h0);
    check("rst_ex_reg2", ex_reg2, 32'h0);
`ifdef ID_EX_SKID_EN
    check("rst_id_ready", id_ready, 1'b0);
`else
    check("rst_id_ready", id_ready, 1'b1);
`endif
    #10 rst_n = 1'b1;
    @(posedge clk);
    #1;
    armed = 1'b1;

    // Vector table.
    for (int i = 0; i < 8; i++) begin
      step(vt[i].iv, vt[i].er, 1'b0, mk(vt[i].r1), a);
      check("tbl_valid", ex_valid, vt[i].exp_v);
      check("tbl_reg1", ex_reg1, vt[i].exp_r1);
    end

    // A, B, C with EX stalled from B's cycle.
    pa = mk(32'h0000_aaa1);
    p0 = pops;
    step(1'b1, 1'b1, 1'b0, pa, a);
    pend.push_back(mk(32'h0000_bbb2));
    pend.push_back(mk(32'h0000_ccc3));
    run(1, 1'b0);
`ifdef ID_EX_SKID_EN
    check("abc_b_taken", pend.size(), 1);
    check("abc_skid_ready", id_ready, 1'b0);
`endif
    run(3, 1'b0);
    check("abc_hold_a", ex_reg1, pa.reg1);
    check("abc_c_waits", pend.size() > 0, 1'b1);
    run(8, 1'b1);
    check("abc_sent", pend.size(), 0);
    check("abc_pops", pops - p0, 3);

    // Back-to-back streaming: 8 accepted in 8 cycles.
    for (int i = 0; i < 8; i++) pend.push_back(mk(32'h5000_0000 + 32'(i * 37)));
    p0 = pops;
    run(8, 1'b1);
    check("stream_no_bubble", pend.size(), 0);
    run(1, 1'b1);
    check("stream_pops", pops - p0, 8);

    // Flush while full with a simultaneous ID transfer.
    step(1'b1, 1'b0, 1'b0, mk(32'h0000_f00d), a);
    pa = mk(32'h0000_dead);
    pa.wd = 5'd7;
    pa.wreg = 1'b1;
    p0 = pops;
    step(1'b1, 1'b1, 1'b1, pa, a);
    check("flush_valid", ex_valid, 1'b0);
    check("flush_wreg", ex_wreg, 1'b0);
    run(3, 1'b1);
    check("flush_dropped", pops - p0, 0);

`ifndef ID_EX_SKID_EN
    // Combinational id_ready follows ex_ready while full.
    step(1'b1, 1'b0, 1'b0, mk(32'h0000_7777), a);
    id_valid = 1'b0;
    ex_ready = 1'b0;
    #1 check("comb_ready_lo", id_ready, 1'b0);
    ex_ready = 1'b1;
    #1 check("comb_ready_hi", id_ready, 1'b1);
    run(2, 1'b1);
`endif

    // Asynchronous reset while holding entries (both slots in the skid build).
    step(1'b1, 1'b0, 1'b0, mk(32'h0000_1111), a);
    step(1'b1, 1'b0, 1'b0, mk(32'h0000_2222), a);
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", ex_valid, 1'b0);
    check("arst_reg2", ex_reg2, 32'h0);
    check("arst_wreg", ex_wreg, 1'b0);
`ifdef ID_EX_SKID_EN
    check("arst_ready", id_ready, 1'b0);
`else
    check("arst_ready", id_ready, 1'b1);
`endif
    q.delete();
    armed = 1'b0;
    id_valid = 1'b0;
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    armed = 1'b1;
    check("post_rst_ready", id_ready, 1'b1);
    run(2, 1'b1);
    pend.push_back(mk(32'h0000_3333));
    run(3, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
